nf_fetch_unit: RTL

NF_FETCH_UNIT -- requirements
Module: nf_fetch_unit

---
 rtl/nf_fetch_unit_pkg.sv | 28 ++
 rtl/nf_fetch_unit_if.sv | 24 ++
 rtl/nf_fetch_unit_skid.sv | 24 ++
 rtl/nf_fetch_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/nf_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, NOP encoding,
// skid entry layout and the sequential PC increment.
package nf_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // NOP used to fill the decode slot after reset (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } skid_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/nf_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between fetch and instruction memory.
interface nf_fetch_unit_if;
  import nf_fetch_unit_pkg::*;

  logic [XLEN-1:0] addr_i;
  logic            req_i;
  logic            ack_i;
  logic [XLEN-1:0] rd_i;

  modport master (
    output addr_i,
    output req_i,
    input  ack_i,
    input  rd_i
  );

  modport slave (
    input  addr_i,
    input  req_i,
    output ack_i,
    output rd_i
  );

endinterface

// File: rtl/nf_fetch_unit_skid.sv
// Skid register holding one fetched instruction and its PC while decode stalls.
module nf_if_skid
  import nf_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  skid_t data_i,
  output skid_t data_o
);

  skid_t data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/nf_fetch_unit.sv
// Instruction fetch stage: single outstanding memory request, one-entry skid for
// decode back-pressure, and branch redirect that drains an in-flight request.
module nf_fetch_unit
  import nf_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  nf_fetch_unit_if.master        imem,
  input  logic                   pc_src,
  input  logic [XLEN-1:0]        pc_branch,
  input  logic                   stall_if,
  output logic [XLEN-1:0]        instr_id,
  output logic [XLEN-1:0]        pc_id,
  output logic                   valid_id
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_id_q;
  logic            valid_q;

  logic            skid_load_d;
  skid_t           skid_data_d;
  skid_t           skid_q;

  // Skid captures only when an ack arrives while decode still holds a live,
  // stalled instruction and no redirect is pending.
  always_comb begin
    skid_load_d       = (state_q == FETCH) && !pc_src && imem.ack_i
                        && valid_q && stall_if;
    skid_data_d.instr = imem.rd_i;
    skid_data_d.pc    = pc_q;
  end

  nf_if_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load_d),
    .data_i (skid_data_d),
    .data_o (skid_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= '0;
      instr_q  <= NOP_INSTR;
      pc_id_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (pc_src) begin
            valid_q <= 1'b0;
            if (imem.ack_i) begin
              pc_q <= pc_branch;
            end else begin
              // Request is already on the bus; keep addr stable and drain it.
              target_q <= pc_branch;
              state_q  <= DROP;
            end
          end else if (imem.ack_i) begin
            pc_q <= pc_inc(pc_q);
            if (!valid_q || !stall_if) begin
              instr_q <= imem.rd_i;
              pc_id_q <= pc_q;
              valid_q <= 1'b1;
            end else begin
              state_q <= HOLD;
            end
          end else if (valid_q && !stall_if) begin
            valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (pc_src) begin
            pc_q    <= pc_branch;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (!stall_if) begin
            instr_q <= skid_q.instr;
            pc_id_q <= skid_q.pc;
            valid_q <= 1'b1;
            state_q <= FETCH;
          end
        end

        DROP: begin
          valid_q <= 1'b0;
          if (imem.ack_i) begin
            pc_q    <= pc_src ? pc_branch : target_q;
            state_q <= FETCH;
          end else if (pc_src) begin
            target_q <= pc_branch;
          end
        end

        default: begin
          state_q <= FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req_i  = (state_q != HOLD);
  assign imem.addr_i = pc_q;
  assign instr_id    = instr_q;
  assign pc_id       = pc_id_q;
  assign valid_id    = valid_q;

endmodule
